xadc_dac_bridge: RTL and testbench

Parametrised bridge from the XADC dynamic reconfiguration port (DRP) to a PmodDA2-style dual 12-bit SPI DAC. On each end-of-conversion it reads the converted channel over DRP and optionally averages 2^AVG_LOG2 samples per channel. It holds the latest result for NUM_CH auxiliary channels and streams two run-time-selected channels to the DAC at a fixed update rate. It sits between the `xadc_wiz_0` instance and the board's JA header, and replaces the free-running clock-divider and DAC-driver pairing.

---
 rtl/xadc_dac_pkg.sv | 19 +
 rtl/da2_serializer.sv | 116 +++++++++++
 rtl/xadc_dac_bridge.sv | 166 ++++++++++++++++
 tb/tb_xadc_dac_bridge.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_dac_pkg.sv
// Shared constants and state encodings for the XADC-to-PmodDA2 bridge.
package xadc_dac_pkg;

   localparam int unsigned DA2_FRAME_BITS = 16;
   localparam int unsigned DA2_PAD_BITS   = 4;
   localparam int unsigned DA2_DATA_W     = 12;

   typedef enum logic {
      D_IDLE,
      D_WAIT
   } drp_state_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_GAP
   } ser_state_t;

endpackage

// File: rtl/da2_serializer.sv
// Shifts two 12-bit words out as one 16-bit PmodDA2 frame on D1/D2, MSB first.
module da2_serializer
   import xadc_dac_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DA2_DATA_W-1:0] data_a,
   input  logic [DA2_DATA_W-1:0] data_b,
   output logic                  dac_sync_n,
   output logic                  dac_sclk,
   output logic                  dac_d1,
   output logic                  dac_d2,
   output logic                  done
);

   localparam int unsigned      HC_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned      BIT_W    = $clog2(DA2_FRAME_BITS);
   localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DA2_FRAME_BITS - 1);

   ser_state_t                state_q, state_d;
   logic [HC_W-1:0]           hc_q, hc_d;
   logic [BIT_W-1:0]          bit_q, bit_d;
   logic                      sclk_q, sclk_d;
   logic                      sync_q, sync_d;
   logic                      done_q, done_d;
   logic [DA2_FRAME_BITS-1:0] sh_a_q, sh_a_d;
   logic [DA2_FRAME_BITS-1:0] sh_b_q, sh_b_d;

   always_comb begin
      state_d = state_q;
      hc_d    = hc_q;
      bit_d   = bit_q;
      sclk_d  = sclk_q;
      sync_d  = sync_q;
      done_d  = 1'b0;
      sh_a_d  = sh_a_q;
      sh_b_d  = sh_b_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SHIFT;
               hc_d    = '0;
               bit_d   = '0;
               sclk_d  = 1'b1;
               sync_d  = 1'b0;
               sh_a_d  = {{DA2_PAD_BITS{1'b0}}, data_a};
               sh_b_d  = {{DA2_PAD_BITS{1'b0}}, data_b};
            end
         end
         S_SHIFT: begin
            if (hc_q == HC_LAST) begin
               hc_d = '0;
               if (sclk_q) begin
                  sclk_d = 1'b0;
               end else if (bit_q == BIT_LAST) begin
                  // Half-period after the last falling edge: release the bus, SCLK idles high
                  sclk_d  = 1'b1;
                  sync_d  = 1'b1;
                  sh_a_d  = '0;
                  sh_b_d  = '0;
                  state_d = S_GAP;
               end else begin
                  sclk_d = 1'b1;
                  bit_d  = bit_q + 1'b1;
                  sh_a_d = sh_a_q << 1;
                  sh_b_d = sh_b_q << 1;
               end
            end else begin
               hc_d = hc_q + 1'b1;
            end
         end
         S_GAP: begin
            if (hc_q == HC_LAST) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               hc_d = hc_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         hc_q    <= '0;
         bit_q   <= '0;
         sclk_q  <= 1'b1;
         sync_q  <= 1'b1;
         done_q  <= 1'b0;
         sh_a_q  <= '0;
         sh_b_q  <= '0;
      end else begin
         state_q <= state_d;
         hc_q    <= hc_d;
         bit_q   <= bit_d;
         sclk_q  <= sclk_d;
         sync_q  <= sync_d;
         done_q  <= done_d;
         sh_a_q  <= sh_a_d;
         sh_b_q  <= sh_b_d;
      end
   end

   assign dac_sync_n = sync_q;
   assign dac_sclk   = sclk_q;
   assign dac_d1     = sh_a_q[DA2_FRAME_BITS-1];
   assign dac_d2     = sh_b_q[DA2_FRAME_BITS-1];
   assign done       = done_q;

endmodule

// File: rtl/xadc_dac_bridge.sv
// Reads XADC conversions over DRP, averages per channel and streams two channels to a PmodDA2.
module xadc_dac_bridge
   import xadc_dac_pkg::*;
#(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned CH_BASE    = 16,
   parameter int unsigned AVG_LOG2   = 0,
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned UPDATE_DIV = 1000,
   localparam int unsigned IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             eoc_in,
   input  logic [4:0]       channel_in,
   output logic             drp_den,
   output logic [6:0]       drp_daddr,
   input  logic             drp_drdy,
   input  logic [15:0]      drp_do,
   input  logic [IDX_W-1:0] sel_a,
   input  logic [IDX_W-1:0] sel_b,
   output logic             dac_sync_n,
   output logic             dac_sclk,
   output logic             dac_d1,
   output logic             dac_d2,
   output logic             dac_done,
   output logic             drp_overrun
);

   localparam int unsigned      ACC_W    = DA2_DATA_W + AVG_LOG2;
   localparam int unsigned      CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int unsigned      UPD_W    = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [UPD_W-1:0] UPD_LAST = UPD_W'(UPDATE_DIV - 1);

   drp_state_t            dstate_q, dstate_d;
   logic                  den_q, den_d;
   logic [6:0]            daddr_q, daddr_d;
   logic [4:0]            ch_q, ch_d;
   logic                  ovr_q, ovr_d;
   logic                  capture;

   logic [DA2_DATA_W-1:0] tbl_q [NUM_CH];
   logic [DA2_DATA_W-1:0] tbl_d [NUM_CH];
   logic [ACC_W-1:0]      acc_q [NUM_CH];
   logic [ACC_W-1:0]      acc_d [NUM_CH];
   logic [CNT_W-1:0]      cnt_q [NUM_CH];
   logic [CNT_W-1:0]      cnt_d [NUM_CH];
   logic [NUM_CH-1:0]     valid_q, valid_d;
   logic [UPD_W-1:0]      upd_q, upd_d;

   logic [31:0]           ch_off;
   logic                  in_range;
   logic [IDX_W-1:0]      idx;
   logic [DA2_DATA_W-1:0] sample;
   logic [ACC_W-1:0]      sum;
   logic                  tick;
   logic [DA2_DATA_W-1:0] data_a, data_b;
   logic                  unused_lsbs;

   assign sample      = drp_do[15:4];
   assign unused_lsbs = ^drp_do[3:0];

   always_comb begin
      dstate_d = dstate_q;
      den_d    = 1'b0;
      daddr_d  = daddr_q;
      ch_d     = ch_q;
      ovr_d    = ovr_q;
      capture  = 1'b0;
      unique case (dstate_q)
         D_IDLE: begin
            if (eoc_in) begin
               den_d    = 1'b1;
               daddr_d  = {2'b00, channel_in};
               ch_d     = channel_in;
               dstate_d = D_WAIT;
            end
         end
         D_WAIT: begin
            if (eoc_in) ovr_d = 1'b1;
            if (drp_drdy) begin
               capture  = 1'b1;
               dstate_d = D_IDLE;
            end
         end
         default: dstate_d = D_IDLE;
      endcase
   end

   // Channels below CH_BASE wrap to huge offsets, so one compare covers both bounds
   assign ch_off   = 32'(ch_q) - CH_BASE;
   assign in_range = ch_off < NUM_CH;
   assign idx      = ch_off[IDX_W-1:0];

   always_comb begin
      tbl_d   = tbl_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      sum     = acc_q[idx] + ACC_W'(sample);
      if (capture && in_range) begin
         if (cnt_q[idx] == CNT_LAST) begin
            tbl_d[idx]   = DA2_DATA_W'(sum >> AVG_LOG2);
            valid_d[idx] = 1'b1;
            acc_d[idx]   = '0;
            cnt_d[idx]   = '0;
         end else begin
            acc_d[idx] = sum;
            cnt_d[idx] = cnt_q[idx] + 1'b1;
         end
      end
   end

   assign tick  = (upd_q == UPD_LAST);
   assign upd_d = tick ? '0 : upd_q + 1'b1;

   assign data_a = (32'(sel_a) < NUM_CH && valid_q[sel_a]) ? tbl_q[sel_a] : '0;
   assign data_b = (32'(sel_b) < NUM_CH && valid_q[sel_b]) ? tbl_q[sel_b] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         dstate_q <= D_IDLE;
         den_q    <= 1'b0;
         daddr_q  <= '0;
         ch_q     <= '0;
         ovr_q    <= 1'b0;
         tbl_q    <= '{default: '0};
         acc_q    <= '{default: '0};
         cnt_q    <= '{default: '0};
         valid_q  <= '0;
         upd_q    <= '0;
      end else begin
         dstate_q <= dstate_d;
         den_q    <= den_d;
         daddr_q  <= daddr_d;
         ch_q     <= ch_d;
         ovr_q    <= ovr_d;
         tbl_q    <= tbl_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         upd_q    <= upd_d;
      end
   end

   da2_serializer #(
      .CLK_DIV (CLK_DIV)
   ) u_ser (
      .clk        (clk),
      .rst        (rst),
      .start      (tick),
      .data_a     (data_a),
      .data_b     (data_b),
      .dac_sync_n (dac_sync_n),
      .dac_sclk   (dac_sclk),
      .dac_d1     (dac_d1),
      .dac_d2     (dac_d2),
      .done       (dac_done)
   );

   assign drp_den     = den_q;
   assign drp_daddr   = daddr_q;
   assign drp_overrun = ovr_q;

endmodule

// File: tb/tb_xadc_dac_bridge.sv
// Scoreboard bench: three bridge instances (bypass, 4x averaging, short update period).
module tb_xadc_dac_bridge;

   localparam int CD      = 2;
   localparam int UD      = 100;
   localparam int UD_FAST = 40;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic eoc = 1'b0;
   logic drdy = 1'b0;
   logic [4:0] chan = '0;
   logic [15:0] ddo = '0;
   logic [1:0] sel_a = '0;
   logic [1:0] sel_b = '0;

   logic [2:0] den, sync_n, sclk, d1, d2, done, ovr;
   logic [2:0][6:0] daddr;

   typedef struct {
      int inst;
      int fall;
      int nbits;
      int low;
      int glitch;
      int done_before;
      logic [15:0] w1;
      logic [15:0] w2;
   } frame_t;

   typedef struct {
      logic [11:0] a;
      logic [11:0] b;
   } exp_t;

   frame_t frm_q[$];
   exp_t   exp_q[$];

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   xadc_dac_bridge #(
      .NUM_CH(4), .CH_BASE(16), .AVG_LOG2(0), .CLK_DIV(CD), .UPDATE_DIV(UD)
   ) u_dut (
      .clk(clk), .rst(rst), .eoc_in(eoc), .channel_in(chan),
      .drp_den(den[0]), .drp_daddr(daddr[0]), .drp_drdy(drdy), .drp_do(ddo),
      .sel_a(sel_a), .sel_b(sel_b),
      .dac_sync_n(sync_n[0]), .dac_sclk(sclk[0]), .dac_d1(d1[0]), .dac_d2(d2[0]),
      .dac_done(done[0]), .drp_overrun(ovr[0])
   );

   xadc_dac_bridge #(
      .NUM_CH(4), .CH_BASE(16), .AVG_LOG2(2), .CLK_DIV(CD), .UPDATE_DIV(UD)
   ) u_avg (
      .clk(clk), .rst(rst), .eoc_in(eoc), .channel_in(chan),
      .drp_den(den[1]), .drp_daddr(daddr[1]), .drp_drdy(drdy), .drp_do(ddo),
      .sel_a(sel_a), .sel_b(sel_b),
      .dac_sync_n(sync_n[1]), .dac_sclk(sclk[1]), .dac_d1(d1[1]), .dac_d2(d2[1]),
      .dac_done(done[1]), .drp_overrun(ovr[1])
   );

   xadc_dac_bridge #(
      .NUM_CH(4), .CH_BASE(16), .AVG_LOG2(0), .CLK_DIV(CD), .UPDATE_DIV(UD_FAST)
   ) u_fast (
      .clk(clk), .rst(rst), .eoc_in(eoc), .channel_in(chan),
      .drp_den(den[2]), .drp_daddr(daddr[2]), .drp_drdy(drdy), .drp_do(ddo),
      .sel_a(sel_a), .sel_b(sel_b),
      .dac_sync_n(sync_n[2]), .dac_sclk(sclk[2]), .dac_d1(d1[2]), .dac_d2(d2[2]),
      .dac_done(done[2]), .drp_overrun(ovr[2])
   );

   // Pin-level DAC monitor: rebuilds each frame from SCLK falling edges
   bit          busy [3];
   int          nb [3], low [3], gl [3], fall_c [3], done_cnt [3], last_done [3];
   logic [15:0] w1 [3], w2 [3];
   logic        p_sync [3], p_sclk [3], p_d1 [3], p_d2 [3];

   always @(negedge clk) begin
      frame_t r;
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            busy[k] = 1'b0;
            nb[k]   = 0;
            low[k]  = 0;
            gl[k]   = 0;
         end else begin
            if (p_sync[k] && !sync_n[k]) begin
               busy[k]   = 1'b1;
               fall_c[k] = cyc;
               nb[k]     = 0;
               low[k]    = 0;
               gl[k]     = 0;
               w1[k]     = '0;
               w2[k]     = '0;
            end
            if (!sync_n[k]) low[k]++;
            if (p_sclk[k] && !sclk[k] && !sync_n[k]) begin
               w1[k] = {w1[k][14:0], d1[k]};
               w2[k] = {w2[k][14:0], d2[k]};
               nb[k]++;
            end
            if ((d1[k] != p_d1[k] || d2[k] != p_d2[k]) && !(!p_sclk[k] && sclk[k])
                && !(p_sync[k] && !sync_n[k]))
               gl[k]++;
            if (!p_sync[k] && sync_n[k] && busy[k]) begin
               r.inst        = k;
               r.fall        = fall_c[k];
               r.nbits       = nb[k];
               r.low         = low[k];
               r.glitch      = gl[k];
               r.done_before = done_cnt[k];
               r.w1          = w1[k];
               r.w2          = w2[k];
               frm_q.push_back(r);
               busy[k] = 1'b0;
            end
            if (done[k]) begin
               done_cnt[k]++;
               last_done[k] = cyc;
            end
         end
         p_sync[k] = sync_n[k];
         p_sclk[k] = sclk[k];
         p_d1[k]   = d1[k];
         p_d2[k]   = d2[k];
      end
   end

   task automatic do_reset(output int rel);
      @(negedge clk);
      rst  = 1'b1;
      eoc  = 1'b0;
      drdy = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rel = cyc;
   endtask

   task automatic drp_txn(input logic [4:0] ch, input logic [15:0] d);
      eoc  = 1'b1;
      chan = ch;
      @(negedge clk);
      eoc = 1'b0;
      @(negedge clk);
      drdy = 1'b1;
      ddo  = d;
      @(negedge clk);
      drdy = 1'b0;
   endtask

   task automatic wait_frame(input int k, input int min_cyc, output frame_t f, output bit ok);
      frame_t t;
      ok     = 1'b0;
      f.inst = -1;
      f.fall = 0;
      f.low  = 0;
      f.nbits = 0;
      f.glitch = 0;
      f.done_before = 0;
      f.w1 = 'x;
      f.w2 = 'x;
      for (int n = 0; n < 400 && !ok; n++) begin
         @(negedge clk);
         while (!ok && frm_q.size() > 0) begin
            t = frm_q.pop_front();
            if (t.inst == k && t.fall >= min_cyc) begin
               f  = t;
               ok = 1'b1;
            end
         end
      end
   endtask

   task automatic test_reset();
      int rel;
      do_reset(rel);
      for (int k = 0; k < 3; k++) begin
         n_vec++;
         if ({den[k], daddr[k], sync_n[k], sclk[k], d1[k], d2[k], done[k], ovr[k]} !==
             {1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values[%0d]: den=%b daddr=%h sync_n=%b sclk=%b d=%b%b done=%b ovr=%b, want 0 00 1 1 00 0 0",
                     k, den[k], daddr[k], sync_n[k], sclk[k], d1[k], d2[k], done[k], ovr[k]);
         end
      end
   endtask

   task automatic test_bypass();
      int rel;
      frame_t f;
      bit ok;
      exp_t e;
      do_reset(rel);
      sel_a = 2'd0;
      sel_b = 2'd0;
      eoc   = 1'b1;
      chan  = 5'd16;
      @(negedge clk);
      eoc = 1'b0;
      n_vec++;
      if ({den[0], daddr[0]} !== {1'b1, 7'h10}) begin
         n_err++;
         $display("FAIL bypass_drp_req: den=%b daddr=%h, want 1 10", den[0], daddr[0]);
      end
      @(negedge clk);
      n_vec++;
      if (den[0] !== 1'b0) begin
         n_err++;
         $display("FAIL bypass_den_width: den=%b on second cycle, want 0", den[0]);
      end
      drdy = 1'b1;
      ddo  = 16'hABC0;
      @(negedge clk);
      drdy = 1'b0;
      e.a = 12'hABC;
      e.b = 12'hABC;
      exp_q.push_back(e);
      wait_frame(0, cyc, f, ok);
      e = exp_q.pop_front();
      n_vec++;
      if (!ok || f.w1 !== {4'h0, e.a} || f.w2 !== {4'h0, e.b}) begin
         n_err++;
         $display("FAIL bypass_frame: seen=%0b d1=%h d2=%h, want %h %h",
                  ok, f.w1, f.w2, {4'h0, e.a}, {4'h0, e.b});
      end
   endtask

   task automatic test_frame_timing();
      frame_t f;
      bit ok;
      wait_frame(0, cyc, f, ok);
      n_vec++;
      if (!ok || f.nbits !== 16 || f.low !== 32 * CD || f.glitch !== 0) begin
         n_err++;
         $display("FAIL frame_shape: seen=%0b falls=%0d sync_low=%0d glitches=%0d, want 16 %0d 0",
                  ok, f.nbits, f.low, f.glitch, 32 * CD);
      end
      repeat (CD + 3) @(negedge clk);
      n_vec++;
      if (!ok || done_cnt[0] - f.done_before !== 1 || last_done[0] - f.fall !== 33 * CD) begin
         n_err++;
         $display("FAIL frame_done: pulses=%0d offset=%0d, want 1 %0d",
                  done_cnt[0] - f.done_before, last_done[0] - f.fall, 33 * CD);
      end
   endtask

   task automatic test_averaging();
      int rel;
      frame_t f;
      bit ok;
      exp_t e;
      logic [11:0] samp [4];
      samp = '{12'h100, 12'h102, 12'h104, 12'h106};
      do_reset(rel);
      sel_a = 2'd0;
      sel_b = 2'd1;
      for (int i = 0; i < 4; i++) begin
         drp_txn(5'd17, {samp[i], 4'h0});
         if (i != 1) begin
            e.a = 12'h000;
            e.b = (i == 3) ? 12'h103 : 12'h000;
            exp_q.push_back(e);
            wait_frame(1, cyc, f, ok);
            e = exp_q.pop_front();
            n_vec++;
            if (!ok || f.w1 !== {4'h0, e.a} || f.w2 !== {4'h0, e.b}) begin
               n_err++;
               $display("FAIL avg_after_sample%0d: seen=%0b d1=%h d2=%h, want %h %h",
                        i + 1, ok, f.w1, f.w2, {4'h0, e.a}, {4'h0, e.b});
            end
         end
      end
   endtask

   task automatic test_out_of_range();
      int rel;
      frame_t f;
      bit ok;
      exp_t e;
      do_reset(rel);
      sel_a = 2'd0;
      sel_b = 2'd3;
      drp_txn(5'd16, 16'h5A50);
      eoc  = 1'b1;
      chan = 5'd3;
      @(negedge clk);
      eoc = 1'b0;
      n_vec++;
      if ({den[0], daddr[0]} !== {1'b1, 7'h03}) begin
         n_err++;
         $display("FAIL oor_drp_req: den=%b daddr=%h, want 1 03", den[0], daddr[0]);
      end
      @(negedge clk);
      drdy = 1'b1;
      ddo  = 16'hFFF0;
      @(negedge clk);
      drdy = 1'b0;
      e.a = 12'h5A5;
      e.b = 12'h000;
      exp_q.push_back(e);
      wait_frame(0, cyc, f, ok);
      e = exp_q.pop_front();
      n_vec++;
      if (!ok || f.w1 !== {4'h0, e.a} || f.w2 !== {4'h0, e.b}) begin
         n_err++;
         $display("FAIL oor_table: seen=%0b d1=%h d2=%h, want %h %h",
                  ok, f.w1, f.w2, {4'h0, e.a}, {4'h0, e.b});
      end
   endtask

   task automatic test_overrun();
      int rel;
      frame_t f;
      bit ok;
      exp_t e;
      do_reset(rel);
      sel_a = 2'd0;
      sel_b = 2'd1;
      n_vec++;
      if (ovr[0] !== 1'b0) begin
         n_err++;
         $display("FAIL ovr_initial: overrun=%b, want 0", ovr[0]);
      end
      eoc  = 1'b1;
      chan = 5'd16;
      @(negedge clk);
      chan = 5'd17;
      @(negedge clk);
      eoc = 1'b0;
      n_vec++;
      if ({den[0], ovr[0]} !== 2'b01) begin
         n_err++;
         $display("FAIL ovr_wait_eoc: den=%b overrun=%b, want 0 1", den[0], ovr[0]);
      end
      drdy = 1'b1;
      ddo  = 16'h3330;
      eoc  = 1'b1;
      @(negedge clk);
      drdy = 1'b0;
      eoc  = 1'b0;
      n_vec++;
      if ({den[0], ovr[0]} !== 2'b01) begin
         n_err++;
         $display("FAIL ovr_drdy_eoc: den=%b overrun=%b, want 0 1", den[0], ovr[0]);
      end
      e.a = 12'h333;
      e.b = 12'h000;
      exp_q.push_back(e);
      wait_frame(0, cyc, f, ok);
      e = exp_q.pop_front();
      n_vec++;
      if (!ok || f.w1 !== {4'h0, e.a} || f.w2 !== {4'h0, e.b} || ovr[0] !== 1'b1) begin
         n_err++;
         $display("FAIL ovr_frame: seen=%0b d1=%h d2=%h overrun=%b, want %h %h 1",
                  ok, f.w1, f.w2, ovr[0], {4'h0, e.a}, {4'h0, e.b});
      end
      do_reset(rel);
      n_vec++;
      if (ovr[0] !== 1'b0) begin
         n_err++;
         $display("FAIL ovr_cleared: overrun=%b after reset, want 0", ovr[0]);
      end
   endtask

   task automatic test_overlap();
      int rel;
      frame_t f1, f2;
      bit ok1, ok2;
      do_reset(rel);
      wait_frame(2, rel, f1, ok1);
      wait_frame(2, f1.fall + 1, f2, ok2);
      n_vec++;
      if (!ok1 || !ok2 || f1.fall - rel !== UD_FAST || f2.fall - f1.fall !== 2 * UD_FAST
          || f1.low !== 32 * CD) begin
         n_err++;
         $display("FAIL overlap_ticks: seen=%0b%0b first=%0d spacing=%0d low=%0d, want %0d %0d %0d",
                  ok1, ok2, f1.fall - rel, f2.fall - f1.fall, f1.low, UD_FAST, 2 * UD_FAST,
                  32 * CD);
      end
   endtask

   task automatic test_reset_mid_frame();
      int rel;
      frame_t f;
      bit ok;
      bit seen;
      exp_t e;
      do_reset(rel);
      sel_a = 2'd0;
      sel_b = 2'd0;
      drp_txn(5'd16, 16'hFFF0);
      seen = 1'b0;
      for (int n = 0; n < 300 && !seen; n++) begin
         @(negedge clk);
         if (busy[0] && nb[0] >= 5) seen = 1'b1;
      end
      n_vec++;
      if (!seen) begin
         n_err++;
         $display("FAIL midrst_reach: fifth falling edge seen=%0b, want 1", seen);
      end
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({sync_n[0], sclk[0], d1[0], d2[0]} !== 4'b1100) begin
         n_err++;
         $display("FAIL midrst_pins: sync_n=%b sclk=%b d1=%b d2=%b, want 1 1 0 0",
                  sync_n[0], sclk[0], d1[0], d2[0]);
      end
      @(negedge clk);
      rst = 1'b0;
      rel = cyc;
      e.a = 12'h000;
      e.b = 12'h000;
      exp_q.push_back(e);
      wait_frame(0, rel, f, ok);
      e = exp_q.pop_front();
      n_vec++;
      if (!ok || f.fall - rel !== UD || f.w1 !== {4'h0, e.a} || f.w2 !== {4'h0, e.b}) begin
         n_err++;
         $display("FAIL midrst_restart: seen=%0b start=%0d d1=%h d2=%h, want %0d %h %h",
                  ok, f.fall - rel, f.w1, f.w2, UD, {4'h0, e.a}, {4'h0, e.b});
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached with %0d vectors applied", n_vec);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_bypass();
      test_frame_timing();
      test_averaging();
      test_out_of_range();
      test_overrun();
      test_overlap();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
